// File: rtl/reaction_timer_pkg.sv
// Shared definitions for the reaction timer: FSM states, display limits and the
// LFSR polynomial used to randomise the wait before the "go" LED.
package reaction_timer_pkg;

    localparam int MAX_MS  = 9999;
    localparam int VALUE_W = 14;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Taps for x^16 + x^14 + x^13 + x^11 + 1 (bits 15, 13, 12, 10).
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        GO,
        DONE,
        ERROR
    } state_t;

    function automatic logic [15:0] lfsr_next(input logic [15:0] q);
        return {q[14:0], ^(q & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Fibonacci LFSR; a non-zero seed keeps it off the all-zero lock-up state.
module lfsr16
    import reaction_timer_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    output logic [15:0] q
);

    always_ff @(posedge clk) begin
        if (reset) begin
            q <= LFSR_SEED;
        end else if (en) begin
            q <= lfsr_next(q);
        end
    end

endmodule

// File: rtl/reaction_timer.sv
// Reaction timer: random wait, light the go LED, count milliseconds until the
// button is pressed; a press during the wait is reported as a false start.
module reaction_timer
    import reaction_timer_pkg::*;
#(
    parameter int CLKS_PER_MS  = 10000,
    parameter int MIN_DELAY_MS = 1000,
    parameter int RAND_BITS    = 11
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               btn,
    output logic [VALUE_W-1:0] value,
    output logic               show_error,
    output logic               led_go
);

    localparam int PRESC_W = (CLKS_PER_MS > 1) ? $clog2(CLKS_PER_MS) : 1;
    localparam int DELAY_W = $clog2(MIN_DELAY_MS + (1 << RAND_BITS));
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(CLKS_PER_MS - 1);
    localparam logic [VALUE_W-1:0] VALUE_MAX  = VALUE_W'(MAX_MS);
    localparam logic [15:0]        RAND_MASK  = 16'((32'd1 << RAND_BITS) - 32'd1);

    logic       btn_meta;
    logic       btn_sync;
    logic       btn_prev;
    logic       btn_rise;
    logic [1:0] settle;

    // The settle count blocks a false edge when btn is already held as reset releases.
    always_ff @(posedge clk) begin
        if (reset) begin
            btn_meta <= 1'b0;
            btn_sync <= 1'b0;
            btn_prev <= 1'b0;
            btn_rise <= 1'b0;
            settle   <= 2'd0;
        end else begin
            btn_meta <= btn;
            btn_sync <= btn_meta;
            btn_prev <= btn_sync;
            btn_rise <= (settle == 2'd3) & btn_sync & ~btn_prev;
            if (settle != 2'd3) begin
                settle <= settle + 2'd1;
            end
        end
    end

    logic [15:0]        lfsr_q;
    logic [15:0]        rand_bits;
    logic [DELAY_W-1:0] delay_seed;

    lfsr16 u_lfsr (
        .clk   (clk),
        .reset (reset),
        .en    (1'b1),
        .q     (lfsr_q)
    );

    assign rand_bits  = lfsr_q & RAND_MASK;
    assign delay_seed = DELAY_W'(MIN_DELAY_MS) + DELAY_W'(rand_bits);

    state_t             state;
    state_t             state_next;
    logic [PRESC_W-1:0] presc;
    logic               tick;
    logic [DELAY_W-1:0] delay_cnt;
    logic [DELAY_W-1:0] delay_next;
    logic [VALUE_W-1:0] value_next;
    logic               show_error_next;
    logic               led_go_next;

    assign tick = (presc == PRESC_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            presc      <= '0;
            delay_cnt  <= '0;
            value      <= '0;
            show_error <= 1'b0;
            led_go     <= 1'b0;
        end else begin
            state      <= state_next;
            delay_cnt  <= delay_next;
            value      <= value_next;
            show_error <= show_error_next;
            led_go     <= led_go_next;
            if (state_next != state || tick) begin
                presc <= '0;
            end else begin
                presc <= presc + PRESC_W'(1);
            end
        end
    end

    always_comb begin
        state_next = state;
        delay_next = delay_cnt;
        value_next = value;

        case (state)
            IDLE: begin
                value_next = '0;
                if (btn_rise) state_next = WAIT;
            end
            WAIT: begin
                if (btn_rise) begin
                    state_next = ERROR;
                end else if (tick) begin
                    delay_next = delay_cnt - DELAY_W'(1);
                    if (delay_cnt == DELAY_W'(1)) state_next = GO;
                end
            end
            GO: begin
                // A press on a tick still takes that tick's increment.
                if (tick) begin
                    if (value == VALUE_MAX) begin
                        state_next = DONE;
                    end else begin
                        value_next = value + VALUE_W'(1);
                    end
                end
                if (btn_rise) state_next = DONE;
            end
            DONE: begin
                if (btn_rise) state_next = WAIT;
            end
            ERROR: begin
                value_next = '0;
                if (btn_rise) state_next = WAIT;
            end
            default: begin
                state_next = IDLE;
                value_next = '0;
            end
        endcase

        if (state_next == WAIT && state != WAIT) begin
            delay_next = delay_seed;
            value_next = '0;
        end
        if (state_next == ERROR) begin
            value_next = '0;
        end

        led_go_next     = (state_next == GO);
        show_error_next = (state_next == ERROR);
    end

endmodule

// File: tb/tb_reaction_timer.sv
// Directed bench for reaction_timer with a timestamp-based model of the expected
// display outputs, checked every cycle, plus hand-computed spot checks.
module tb_reaction_timer;

    localparam int CLKS   = 4;
    localparam int MIN_MS = 5;
    localparam int RB     = 2;
    localparam int MAX_V  = 9999;

    logic        clk = 1'b0;
    logic        reset;
    logic        btn;
    logic [13:0] value;
    logic        show_error;
    logic        led_go;

    reaction_timer #(
        .CLKS_PER_MS  (CLKS),
        .MIN_DELAY_MS (MIN_MS),
        .RAND_BITS    (RB)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .btn        (btn),
        .value      (value),
        .show_error (show_error),
        .led_go     (led_go)
    );

    // clock / reset block
    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;
    int cyc     = 0;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation ran past its time limit at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic timeout(input string name);
        n_total++;
        n_bad++;
        $display("FAIL %s: wait expired at cycle %0d", name, cyc);
    endtask

    // Behavioural model: phase + entry timestamp; ms elapsed is plain division.
    typedef enum {M_IDLE, M_WAIT, M_GO, M_DONE, M_ERROR} mode_t;
    mode_t       m_mode;
    int          m_edge;
    int          m_t;
    int          m_delay;
    int          m_ms;
    bit          m_rise;
    bit          m_tick;
    logic [15:0] m_lfsr;
    logic [4:0]  m_hist;
    int          exp_value;
    bit          exp_err;
    bit          exp_go;
    bit          m_valid = 1'b0;

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    always @(posedge clk) begin
        cyc++;
        if (reset) begin
            m_mode    = M_IDLE;
            m_edge    = 0;
            m_t       = 0;
            m_delay   = 0;
            m_lfsr    = 16'hACE1;
            m_hist    = '0;
            exp_value = 0;
            exp_err   = 1'b0;
            exp_go    = 1'b0;
            m_valid   = 1'b1;
        end else begin
            m_edge++;
            m_hist = {m_hist[3:0], btn};
            // A press is acted on 3 edges after it is first sampled high.
            m_rise = (m_edge >= 5) && m_hist[3] && !m_hist[4];
            m_ms   = (m_edge - m_t) / CLKS;
            m_tick = ((m_edge - m_t) % CLKS) == 0;
            if (m_rise && (m_mode == M_IDLE || m_mode == M_DONE || m_mode == M_ERROR)) begin
                m_mode    = M_WAIT;
                m_t       = m_edge;
                m_delay   = MIN_MS + int'(m_lfsr % (1 << RB));
                exp_value = 0;
                exp_err   = 1'b0;
                exp_go    = 1'b0;
            end else if (m_mode == M_WAIT) begin
                if (m_rise) begin
                    m_mode  = M_ERROR;
                    m_t     = m_edge;
                    exp_err = 1'b1;
                end else if (m_tick && m_ms == m_delay) begin
                    m_mode = M_GO;
                    m_t    = m_edge;
                    exp_go = 1'b1;
                end
            end else if (m_mode == M_GO) begin
                exp_value = (m_ms > MAX_V) ? MAX_V : m_ms;
                if (m_rise || (m_tick && m_ms > MAX_V)) begin
                    m_mode = M_DONE;
                    m_t    = m_edge;
                    exp_go = 1'b0;
                end
            end
            m_lfsr = lfsr_step(m_lfsr);
        end
    end

    // scoreboard: compare every cycle away from the active edge
    always @(negedge clk) begin
        if (m_valid) begin
            check("value", 32'(value), exp_value);
            check("show_error", 32'(show_error), 32'(exp_err));
            check("led_go", 32'(led_go), 32'(exp_go));
        end
    end

    // driver tasks
    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input int hold);
        @(negedge clk);
        btn = 1'b1;
        repeat (hold) @(negedge clk);
        btn = 1'b0;
    endtask

    task automatic wait_led(input bit level, input int budget, input string name, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (led_go === level) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) timeout(name);
    endtask

    int s_edge;
    int g_edge;
    int x_edge;
    bit ok;
    bit seen_go;

    initial begin
        reset = 1'b1;
        btn   = 1'b0;
        idle(4);
        check("reset_value", 32'(value), 0);
        check("reset_led_go", 32'(led_go), 0);
        reset = 1'b0;
        idle(10);

        // first round: latency from sampled press to go LED
        @(negedge clk);
        btn    = 1'b1;
        s_edge = cyc + 1;
        repeat (2) @(negedge clk);
        btn = 1'b0;
        wait_led(1'b1, 200, "go_rise", ok);
        if (ok) check("go_latency", 32'(cyc - s_edge), 32'(3 + CLKS * m_delay));

        // let 37 ms elapse, then press between ticks
        g_edge = cyc;
        repeat (146) @(negedge clk);
        btn = 1'b1;
        repeat (3) @(negedge clk);
        btn = 1'b0;
        wait_led(1'b0, 20, "go_fall_37", ok);
        check("done_value_37", 32'(value), 37);
        check("done_no_error", 32'(show_error), 0);
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            check("hold_37", 32'(value), 37);
        end

        // false start: second press during the wait
        press(2);
        idle(3);
        press(2);
        idle(6);
        check("false_start_err", 32'(show_error), 1);
        check("false_start_value", 32'(value), 0);
        check("false_start_led", 32'(led_go), 0);

        // new round clears the error; press lands exactly on the expiry tick
        press(2);
        idle(3);
        check("err_cleared", 32'(show_error), 0);
        x_edge = m_t + CLKS * m_delay;
        if (x_edge - 4 > cyc) repeat (x_edge - 4 - cyc) @(negedge clk);
        btn = 1'b1;
        repeat (2) @(negedge clk);
        btn = 1'b0;
        idle(3);
        check("expiry_tie_err", 32'(show_error), 1);
        check("expiry_tie_led", 32'(led_go), 0);

        // reset in the middle of counting, button held through release
        press(2);
        wait_led(1'b1, 200, "go_rise_reset", ok);
        repeat (2000) @(negedge clk);
        check("pre_reset_500", 32'(value), 500);
        reset = 1'b1;
        btn   = 1'b1;
        @(negedge clk);
        check("mid_reset_value", 32'(value), 0);
        check("mid_reset_led", 32'(led_go), 0);
        check("mid_reset_err", 32'(show_error), 0);
        repeat (2) @(negedge clk);
        reset   = 1'b0;
        seen_go = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (led_go) seen_go = 1'b1;
        end
        check("held_btn_no_round", 32'(seen_go), 0);
        btn = 1'b0;
        idle(5);

        // timeout: never press during go
        press(2);
        wait_led(1'b1, 200, "go_rise_timeout", ok);
        wait_led(1'b0, 40100, "timeout_done", ok);
        check("timeout_value", 32'(value), 9999);
        idle(20);
        check("timeout_hold", 32'(value), 9999);

        // press on the tick that takes 9998 to 9999
        press(2);
        wait_led(1'b1, 200, "go_rise_sat", ok);
        g_edge = cyc;
        repeat (39992) @(negedge clk);
        check("pre_sat_9998", 32'(value), 9998);
        btn = 1'b1;
        repeat (2) @(negedge clk);
        btn = 1'b0;
        repeat (3) @(negedge clk);
        check("sat_tie_value", 32'(value), 9999);
        check("sat_tie_led", 32'(led_go), 0);
        idle(5);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
